// File: rtl/dual_port_memory_pkg.sv
// dual_port_memory_pkg: shared types and constants for the dual-port instruction/data memory
package dual_port_memory_pkg;
  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD} mem_size_t;
  typedef enum logic {INIT, READY} mem_state_t;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
endpackage

// File: rtl/dual_port_memory_strobe_gen.sv
// mem_strobe_gen: byte strobes, lane-replicated store data and misalignment flag for the data port
module mem_strobe_gen
  import dual_port_memory_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [3:0]  strb,
  output logic [31:0] wword,
  output logic        misaligned
);
  always_comb begin
    misaligned = size == SIZE_RSVD || (size == SIZE_HALF && offset[0]) || (size == SIZE_WORD && offset != 2'd0);
    strb = size == SIZE_BYTE ? 4'b0001 << offset :
           size == SIZE_HALF ? (offset[1] ? 4'b1100 : 4'b0011) :
           size == SIZE_WORD ? 4'b1111 : 4'b0000;
    wword = size == SIZE_BYTE ? {4{wdata[7:0]}} :
            size == SIZE_HALF ? {2{wdata[15:0]}} : wdata;
  end
endmodule

// File: rtl/dual_port_memory.sv
// dual_port_memory: fetch + load/store RAM with 1-cycle handshake and post-reset init sweep
module dual_port_memory
  import dual_port_memory_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = RV_NOP
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       init_busy,
  input  logic                       i_req,
  input  logic [ADDRESS_WIDTH+1:0]   i_addr,
  output logic                       i_ready,
  output logic                       i_valid,
  output logic [DATA_WIDTH-1:0]      i_rdata,
  output logic                       i_fault,
  input  logic                       d_req,
  input  logic                       d_we,
  input  logic [1:0]                 d_size,
  input  logic [ADDRESS_WIDTH+1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]      d_wdata,
  output logic                       d_ready,
  output logic                       d_valid,
  output logic [DATA_WIDTH-1:0]      d_rdata,
  output logic                       d_fault
);
  localparam int MEMORY_DEPTH = 1 << ADDRESS_WIDTH;

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("dual_port_memory supports only DATA_WIDTH == 32");
  end

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
  mem_state_t state, next_state;
  logic [ADDRESS_WIDTH-1:0] cnt;
  logic [3:0] strb;
  logic [31:0] wword;
  logic misaligned, i_acc, d_acc, i_mis;
  logic [ADDRESS_WIDTH-1:0] i_word, d_word;

  mem_strobe_gen u_strobe (
    .size(mem_size_t'(d_size)),
    .offset(d_addr[1:0]),
    .wdata(d_wdata),
    .strb(strb),
    .wword(wword),
    .misaligned(misaligned)
  );

  always_comb begin
    next_state = (state == INIT && cnt == {ADDRESS_WIDTH{1'b1}}) ? READY : state;
    init_busy = state == INIT;
    i_ready = state == READY;
    d_ready = state == READY;
    i_acc = i_req && i_ready;
    d_acc = d_req && d_ready;
    i_mis = i_addr[1:0] != 2'd0;
    i_word = i_addr[ADDRESS_WIDTH+1:2];
    d_word = d_addr[ADDRESS_WIDTH+1:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= next_state;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  // Array has no reset; the init sweep overwrites it after every reset
  always_ff @(posedge clk) begin
    if (state == INIT) mem[cnt] <= INIT_VALUE;
    else if (d_acc && d_we && !misaligned)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem[d_word][8*b +: 8] <= wword[8*b +: 8];
  end

  // Nonblocking reads give read-first behaviour against a same-cycle store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_valid <= 1'b0;
      i_fault <= 1'b0;
      i_rdata <= '0;
      d_valid <= 1'b0;
      d_fault <= 1'b0;
      d_rdata <= '0;
    end else begin
      i_valid <= i_acc;
      d_valid <= d_acc;
      if (i_acc) begin
        i_fault <= i_mis;
        i_rdata <= i_mis ? '0 : mem[i_word];
      end
      if (d_acc) begin
        d_fault <= misaligned;
        d_rdata <= (misaligned || d_we) ? '0 : mem[d_word];
      end
    end
  end
endmodule

// File: tb/tb_dual_port_memory.sv
// tb_dual_port_memory: random + directed checks against a behavioural memory model
module tb_dual_port_memory;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic init_busy, i_req, i_ready, i_valid, i_fault;
  logic [7:0] i_addr, d_addr;
  logic [31:0] i_rdata, d_wdata, d_rdata;
  logic d_req, d_we, d_ready, d_valid, d_fault;
  logic [1:0] d_size;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  logic [31:0] mm [64];
  int since;
  logic m_iv, m_if, m_dv, m_df, bad;
  logic [31:0] m_ir, m_dr;

  dual_port_memory dut (
    .clk(clk), .rst_n(rst_n), .init_busy(init_busy),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid),
    .i_rdata(i_rdata), .i_fault(i_fault),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata), .d_fault(d_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: memory is ready 64 cycles after release and then acts as a byte array
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since = 0;
      {m_iv, m_if, m_dv, m_df} = '0;
      m_ir = 0;
      m_dr = 0;
    end else begin
      m_iv = 0;
      m_dv = 0;
      if (since >= 64 && i_req) begin
        m_iv = 1;
        m_if = i_addr % 4 != 0;
        m_ir = m_if ? 0 : mm[i_addr / 4];
      end
      if (since >= 64 && d_req) begin
        bad = d_size == 3 || d_addr % (1 << d_size) != 0;
        m_dv = 1;
        m_df = bad;
        m_dr = (bad || d_we) ? 0 : mm[d_addr / 4];
        if (d_we && !bad)
          for (int k = 0; k < (1 << d_size); k++)
            mm[d_addr / 4][8 * (d_addr % 4 + k) +: 8] = d_wdata[8 * k +: 8];
      end
      if (since < 64) begin
        since++;
        if (since == 64) for (int w = 0; w < 64; w++) mm[w] = 32'h0000_0013;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("init_busy", init_busy, since < 64);
      chk("i_ready", i_ready, since >= 64);
      chk("d_ready", d_ready, since >= 64);
      chk("i_valid", i_valid, m_iv);
      chk("d_valid", d_valid, m_dv);
      chk("i_fault", i_fault, m_if);
      chk("d_fault", d_fault, m_df);
      chk("i_rdata", i_rdata, m_ir);
      chk("d_rdata", d_rdata, m_dr);
    end
  end

  task automatic op(input logic ir, input logic [7:0] ia, input logic dr, input logic we,
                    input logic [1:0] sz, input logic [7:0] da, input logic [31:0] wd);
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = we; d_size = sz; d_addr = da; d_wdata = wd;
    @(negedge clk); #1;
    i_req = 0; d_req = 0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (init_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("init_len", n, 64);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    @(negedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    {i_req, d_req, d_we} = '0;
    i_addr = 0; d_addr = 0; d_size = 0; d_wdata = 0;
    #3 rst_n = 0;
    chk_en = 1;
    @(negedge clk); #1;
    chk("rst_i_ready", i_ready, 0);
    chk("rst_busy", init_busy, 1);
    rst_n = 1;
    wait_init();
    op(1, 8'h00, 0, 0, 0, 0, 0);
    chk("fetch0", i_rdata, 32'h0000_0013);
    op(1, 8'hFC, 0, 0, 0, 0, 0);
    chk("fetchFC", i_rdata, 32'h0000_0013);
    chk("fetchFC_fault", i_fault, 0);
    op(0, 0, 1, 1, 2, 8'h10, 32'hDEADBEEF);
    chk("sw_ack", {d_valid, d_fault}, 2'b10);
    op(1, 8'h10, 0, 0, 0, 0, 0);
    chk("fetch_after_sw", i_rdata, 32'hDEADBEEF);
    op(0, 0, 1, 1, 0, 8'h11, 32'h0000_00AA);
    op(0, 0, 1, 0, 2, 8'h10, 0);
    chk("lw_after_sb", d_rdata, 32'hDEADAAEF);
    op(0, 0, 1, 1, 1, 8'h12, 32'h0000_1234);
    op(0, 0, 1, 0, 2, 8'h10, 0);
    chk("lw_after_sh", d_rdata, 32'h1234AAEF);
    op(0, 0, 1, 1, 2, 8'h12, 32'hFFFF_FFFF);
    chk("sw_mis", d_fault, 1);
    op(0, 0, 1, 0, 1, 8'h13, 0);
    chk("lh_mis", {d_fault, d_rdata}, {1'b1, 32'h0});
    op(0, 0, 1, 0, 2, 8'h10, 0);
    chk("lw_unchanged", d_rdata, 32'h1234AAEF);
    op(0, 0, 1, 0, 3, 8'h14, 0);
    chk("rsvd_size", d_fault, 1);
    op(1, 8'h02, 0, 0, 0, 0, 0);
    chk("fetch_mis", {i_fault, i_rdata}, {1'b1, 32'h0});
    op(1, 8'h20, 1, 1, 2, 8'h20, 32'h5555_5555);
    chk("read_first", i_rdata, 32'h0000_0013);
    op(1, 8'h20, 0, 0, 0, 0, 0);
    chk("fetch_new", i_rdata, 32'h5555_5555);
    for (int c = 0; c < 3000; c++) begin
      i_req = $urandom_range(0, 1);
      i_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
      d_req = $urandom_range(0, 1);
      d_we = $urandom_range(0, 1);
      d_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      d_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
      d_wdata = $urandom;
      @(negedge clk); #1;
    end
    i_req = 0; d_req = 0;
    pulse_reset();
    repeat (30) @(negedge clk);
    #1;
    pulse_reset();
    wait_init();
    op(1, 8'h20, 0, 0, 0, 0, 0);
    chk("fetch_after_rst", i_rdata, 32'h0000_0013);
    d_req = 1; d_we = 0; d_size = 2; d_addr = 8'h10;
    #2 rst_n = 0;
    @(negedge clk); #1;
    d_req = 0;
    chk("no_valid_in_rst", d_valid, 0);
    rst_n = 1;
    wait_init();
    op(0, 0, 1, 0, 2, 8'h10, 0);
    chk("load_after_rst", d_rdata, 32'h0000_0013);
    op(1, 8'h14, 0, 0, 0, 0, 0);
    chk("fetch_after_rst2", i_rdata, 32'h0000_0013);
    @(negedge clk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
